// File: rtl/fb_port_arbiter.sv
// rtl/fb_port_arbiter.sv - frame-buffer owner: camera write FIFO, capture FSM, read/write arbitration
module fb_port_arbiter #(
   parameter int FB_WIDTH    = 160,
   parameter int FB_HEIGHT   = 120,
   parameter int ADDR_W      = 15,
   parameter int DATA_W      = 16,
   parameter int WFIFO_DEPTH = 4,
   parameter int RD_LATENCY  = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cam_vsync,
   input  logic              cam_valid,
   input  logic [DATA_W-1:0] cam_data,
   input  logic              disp_rd_req,
   input  logic [ADDR_W-1:0] disp_rd_addr,
   output logic              disp_rd_gnt,
   output logic              disp_rd_valid,
   output logic [DATA_W-1:0] disp_rd_data,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_wr_en,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_rd_en,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              wr_overflow,
   output logic              frame_done
);

   localparam int                N         = FB_WIDTH * FB_HEIGHT;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);
   localparam int                PTR_W     = $clog2(WFIFO_DEPTH);
   localparam logic [PTR_W:0]    CNT_ONE   = (PTR_W + 1)'(1);
   localparam logic [PTR_W:0]    CNT_FULL  = (PTR_W + 1)'(WFIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, CAPTURE, FULL} cap_state_t;

   cap_state_t        state, state_nxt;
   logic [ADDR_W-1:0] wr_ptr, wr_ptr_nxt;
   logic              vsync_q;
   logic              vsync_rise;
   logic              push_req;
   logic              push_ok;
   logic              overflow_set;

   logic [ADDR_W-1:0] fifo_addr [WFIFO_DEPTH];
   logic [DATA_W-1:0] fifo_data [WFIFO_DEPTH];
   logic [PTR_W-1:0]  wr_idx, rd_idx;
   logic [PTR_W:0]    count;
   logic              fifo_full, fifo_nonempty;
   logic [ADDR_W-1:0] head_addr;
   logic [DATA_W-1:0] head_data;

   logic              do_wr, do_rd;
   logic [RD_LATENCY-1:0] rd_pipe;
   logic [RD_LATENCY:0]   rd_pipe_in;

   assign vsync_rise    = cam_vsync & ~vsync_q;
   assign fifo_full     = (count == CNT_FULL);
   assign fifo_nonempty = (count != '0);
   assign head_addr     = fifo_addr[rd_idx];
   assign head_data     = fifo_data[rd_idx];

   // Capture FSM: a vsync edge always wins and restarts addressing at 0
   always_comb begin
      state_nxt  = state;
      wr_ptr_nxt = wr_ptr;
      push_req   = 1'b0;
      if (vsync_rise) begin
         state_nxt  = CAPTURE;
         wr_ptr_nxt = '0;
      end else if (state == CAPTURE && cam_valid) begin
         push_req = 1'b1;
         if (wr_ptr == LAST_ADDR)
            state_nxt = FULL;
         else
            wr_ptr_nxt = wr_ptr + ADDR_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         wr_ptr  <= '0;
         vsync_q <= 1'b0;
      end else begin
         state   <= state_nxt;
         wr_ptr  <= wr_ptr_nxt;
         vsync_q <= cam_vsync;
      end
   end

   // A full FIFO forces a write so the camera never stalls; otherwise reads win
   always_comb begin
      do_wr = 1'b0;
      do_rd = 1'b0;
      if (rst_n) begin
         if (fifo_full)
            do_wr = 1'b1;
         else if (disp_rd_req)
            do_rd = 1'b1;
         else if (fifo_nonempty)
            do_wr = 1'b1;
      end
   end

   assign mem_wr_en   = do_wr;
   assign mem_rd_en   = do_rd;
   assign disp_rd_gnt = do_rd;
   assign mem_addr    = do_rd ? disp_rd_addr : (do_wr ? head_addr : '0);
   assign mem_wdata   = do_wr ? head_data : '0;

   assign push_ok      = push_req && (!fifo_full || do_wr);
   assign overflow_set = push_req && fifo_full && !do_wr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < WFIFO_DEPTH; i++) begin
            fifo_addr[i] <= '0;
            fifo_data[i] <= '0;
         end
         wr_idx <= '0;
         rd_idx <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            fifo_addr[wr_idx] <= wr_ptr;
            fifo_data[wr_idx] <= cam_data;
            wr_idx            <= wr_idx + PTR_W'(1);
         end
         if (do_wr)
            rd_idx <= rd_idx + PTR_W'(1);
         if (push_ok && !do_wr)
            count <= count + CNT_ONE;
         else if (!push_ok && do_wr)
            count <= count - CNT_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_overflow <= 1'b0;
         frame_done  <= 1'b0;
      end else begin
         if (vsync_rise)
            wr_overflow <= 1'b0;
         else if (overflow_set)
            wr_overflow <= 1'b1;
         frame_done <= do_wr && (head_addr == LAST_ADDR);
      end
   end

   // Grant delay line matches the BSRAM latency; data is then registered once more
   assign rd_pipe_in = {rd_pipe, do_rd};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_pipe       <= '0;
         disp_rd_valid <= 1'b0;
         disp_rd_data  <= '0;
      end else begin
         rd_pipe       <= rd_pipe_in[RD_LATENCY-1:0];
         disp_rd_valid <= rd_pipe[RD_LATENCY-1];
         if (rd_pipe[RD_LATENCY-1])
            disp_rd_data <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// tb/tb_fb_port_arbiter.sv - scoreboard bench for fb_port_arbiter with BSRAM model
module tb_fb_port_arbiter;

   localparam int N     = 160 * 120;
   localparam int AW    = 15;
   localparam int DW    = 16;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cam_vsync, cam_valid;
   logic [DW-1:0] cam_data;
   logic          disp_rd_req;
   logic [AW-1:0] disp_rd_addr;
   logic          disp_rd_gnt, disp_rd_valid;
   logic [DW-1:0] disp_rd_data;
   logic [AW-1:0] mem_addr;
   logic          mem_wr_en, mem_rd_en;
   logic [DW-1:0] mem_wdata, mem_rdata;
   logic          wr_overflow, frame_done;

   always #5 clk = ~clk;

   fb_port_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .cam_vsync(cam_vsync), .cam_valid(cam_valid), .cam_data(cam_data),
      .disp_rd_req(disp_rd_req), .disp_rd_addr(disp_rd_addr),
      .disp_rd_gnt(disp_rd_gnt), .disp_rd_valid(disp_rd_valid), .disp_rd_data(disp_rd_data),
      .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata),
      .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
      .wr_overflow(wr_overflow), .frame_done(frame_done)
   );

   // Single-port BSRAM, one-cycle read latency
   logic [DW-1:0] bsram [2**AW];
   always @(posedge clk) begin
      if (mem_wr_en) bsram[mem_addr] <= mem_wdata;
      if (mem_rd_en) mem_rdata <= bsram[mem_addr];
   end

   typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
   typedef struct packed { logic [DW-1:0] d; int due; } rd_t;

   wr_t           exp_wr [$];
   rd_t           rd_q [$];
   logic [DW-1:0] shadow [2**AW];
   logic [DW-1:0] ref_frame [N];
   int            checks = 0, failures = 0;
   int            cyc = 0, rd_returns = 0, fd_count = 0, full_writes = 0;
   logic [DW-1:0] last_rd_data;
   bit            push_now = 0, cap = 0, fd_exp = 0;
   int            ptr = 0;
   int            rd_mode = 0;
   logic [AW-1:0] rd_fixed = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Monitor / scoreboard: arbitration rules, write order, read data and latency
   always @(negedge clk) begin
      int  cnt;
      bit  full, ew, eg;
      wr_t w;
      rd_t r;
      cyc++;
      if (!rst_n) begin
         check("reset_strobes", 32'({mem_wr_en, mem_rd_en, disp_rd_gnt, disp_rd_valid, wr_overflow, frame_done}), 0);
         check("reset_buses", 32'(|{mem_addr, mem_wdata, disp_rd_data}), 0);
         exp_wr.delete();
         rd_q.delete();
         fd_exp = 0;
      end else begin
         cnt  = exp_wr.size() - int'(push_now);
         full = (cnt >= DEPTH);
         ew   = full || (!disp_rd_req && cnt > 0);
         eg   = !full && disp_rd_req;
         check("arb_wr_en", 32'(mem_wr_en), 32'(ew));
         check("arb_gnt", 32'(disp_rd_gnt), 32'(eg));
         check("arb_rd_en", 32'(mem_rd_en), 32'(eg));
         check("frame_done", 32'(frame_done), 32'(fd_exp));
         check("wr_overflow", 32'(wr_overflow), 0);
         if (frame_done) fd_count++;
         fd_exp = 0;
         if (mem_wr_en) begin
            if (disp_rd_req) full_writes++;
            check("write_expected", 32'(exp_wr.size() != 0), 1);
            if (exp_wr.size() != 0) begin
               w = exp_wr.pop_front();
               check("wr_addr", 32'(mem_addr), 32'(w.a));
               check("wr_data", 32'(mem_wdata), 32'(w.d));
               shadow[w.a] = w.d;
               if (int'(w.a) == N - 1) fd_exp = 1;
            end
         end
         if (disp_rd_gnt) begin
            check("rd_addr", 32'(mem_addr), 32'(disp_rd_addr));
            rd_q.push_back('{d: shadow[disp_rd_addr], due: cyc + 2});
         end
         if (disp_rd_valid) begin
            check("rd_valid_expected", 32'(rd_q.size() != 0), 1);
            if (rd_q.size() != 0) begin
               r = rd_q.pop_front();
               check("rd_data", 32'(disp_rd_data), 32'(r.d));
               check("rd_latency", 32'(cyc), 32'(r.due));
               last_rd_data = disp_rd_data;
               rd_returns++;
            end
         end
      end
   end

   // Display requester: holds request until granted, then moves on
   initial begin
      bit g, single_sent;
      disp_rd_req  = 1'b0;
      disp_rd_addr = '0;
      single_sent  = 0;
      forever begin
         @(negedge clk);
         g = disp_rd_gnt;
         @(posedge clk);
         #1;
         case (rd_mode)
            1: if (!disp_rd_req || g) begin
                  disp_rd_req  = 1'b1;
                  disp_rd_addr = AW'($urandom_range(0, N - 1));
               end
            2: if (g) begin
                  disp_rd_req = 1'b0;
                  single_sent = 1;
               end else if (!single_sent && !disp_rd_req) begin
                  disp_rd_req  = 1'b1;
                  disp_rd_addr = rd_fixed;
               end
            default: begin
               disp_rd_req = 1'b0;
               single_sent = 0;
            end
         endcase
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      cam_valid = 1'b0;
      push_now  = 0;
      repeat (n) step();
   endtask

   task automatic vsync();
      cam_valid = 1'b0;
      push_now  = 0;
      cam_vsync = 1'b1;
      step();
      cam_vsync = 1'b0;
      cap = 1;
      ptr = 0;
   endtask

   task automatic pixel();
      cam_valid = 1'b1;
      cam_data  = DW'($urandom);
      if (cap && ptr < N) begin
         exp_wr.push_back('{a: AW'(ptr), d: cam_data});
         ref_frame[ptr] = cam_data;
         push_now = 1;
         ptr++;
      end else begin
         push_now = 0;
      end
      step();
   endtask

   task automatic drain(input string name);
      int k = 0;
      idle(1);
      while (exp_wr.size() != 0 && k < 200) begin
         step();
         k++;
      end
      idle(4);
      check(name, 32'(exp_wr.size()), 0);
   endtask

   initial begin
      int rr, fw0;
      rst_n     = 1'b0;
      cam_vsync = 1'b0;
      cam_valid = 1'b0;
      cam_data  = '0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(3);

      // T1: full frame with random gaps, then excess pixels in FULL
      vsync();
      for (int i = 0; i < N; i++) begin
         pixel();
         if ($urandom_range(0, 1) == 1) idle(1);
      end
      repeat (3) pixel();
      drain("t1_drain");
      check("t1_frame_done_count", 32'(fd_count), 1);
      check("t1_overflow", 32'(wr_overflow), 0);

      // T4: single read of 0x0123
      rd_fixed = AW'(12'h123);
      rr = rd_returns;
      rd_mode = 2;
      for (int k = 0; k < 20 && rd_returns == rr; k++) step();
      check("t4_read_returned", 32'(rd_returns - rr), 1);
      check("t4_read_data", 32'(last_rd_data), 32'(ref_frame[12'h123]));
      rd_mode = 0;
      idle(3);

      // T2: continuous reads, 1 pixel per 5 cycles; full FIFO must steal cycles
      fw0 = full_writes;
      rd_mode = 1;
      idle(2);
      vsync();
      for (int i = 0; i < 200; i++) begin
         pixel();
         idle(4);
      end
      check("t2_full_writes_seen", 32'(full_writes > fw0), 1);

      // T3: pixel every cycle with continuous reads
      vsync();
      repeat (60) pixel();
      rd_mode = 0;
      drain("t3_drain");

      // T5: mid-frame vsync with entries still queued
      rd_mode = 1;
      vsync();
      for (int i = 0; i < 1000; i++) begin
         pixel();
         if ($urandom_range(0, 3) == 0) idle(1);
      end
      vsync();
      repeat (20) pixel();
      rd_mode = 0;
      drain("t5_drain");

      // T6: reset with 3 queued writes and a read in flight
      rd_mode = 1;
      idle(3);
      vsync();
      repeat (3) pixel();
      cam_valid = 1'b0;
      push_now  = 0;
      rst_n     = 1'b0;
      cap       = 0;
      rd_mode   = 0;
      #1;
      check("t6_async_strobes", 32'({mem_wr_en, mem_rd_en, disp_rd_gnt, disp_rd_valid, frame_done}), 0);
      repeat (3) step();
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         pixel();
         idle(1);
      end
      idle(10);
      check("t6_no_stray_reads", 32'(rd_q.size()), 0);
      vsync();
      repeat (5) pixel();
      drain("t6_drain");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

endmodule
